wb_register_bank_ppc2simulink: RTL and testbench

WB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: wb_register_bank_ppc2simulink

---
 rtl/wb_register_bank_ppc2simulink_pkg.sv | 16 +
 rtl/wb_register_bank_ppc2simulink_if.sv | 15 +
 rtl/wb_register_bank_ppc2simulink_wb_reg_slice.sv | 52 +++++
 rtl/wb_register_bank_ppc2simulink.sv | 82 ++++++++
 tb/tb_wb_register_bank_ppc2simulink.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_register_bank_ppc2simulink_pkg.sv
// wb_register_bank_ppc2simulink_pkg: shared constants and byte-lane merge helper
package wb_register_bank_ppc2simulink_pkg;
    localparam int MAX_REGS = 16;
    localparam int IDX_W = $clog2(MAX_REGS + 1);
    localparam int CNT_W = 16;
    localparam int CTRL_MODE_BIT = 0;
    localparam int CTRL_DIRTY_BIT = 1;
    localparam int CTRL_CNT_LSB = 16;
    localparam int CTRL_COMMIT_BIT = 0;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/wb_register_bank_ppc2simulink_if.sv
// wb_register_bank_ppc2simulink_if: Wishbone request/response bundle
interface wb_register_bank_ppc2simulink_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master(output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, input wb_dat_o, wb_ack_o, wb_err_o);
    modport slave(input wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, output wb_dat_o, wb_ack_o, wb_err_o);
endinterface

// File: rtl/wb_register_bank_ppc2simulink_wb_reg_slice.sv
// wb_reg_slice: one register's shadow, output, dirty flag and valid pulse
module wb_reg_slice
    import wb_register_bank_ppc2simulink_pkg::*;
#(
    parameter int COMMIT_MODE = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wr_i,
    input  logic        commit_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] shadow_o,
    output logic [31:0] out_o,
    output logic        dirty_o,
    output logic        valid_o
);
    localparam bit DIRECT = (COMMIT_MODE == 0);

    logic [31:0] shadow_q, shadow_d, out_q, out_d, merged;
    logic        dirty_q, dirty_d, valid_q, valid_d, wr;

    // next state: direct mode mirrors writes to the output, commit mode defers them until a commit
    always_comb begin
        merged   = merge_bytes(shadow_q, dat_i, sel_i);
        wr       = wr_i && (sel_i != 4'h0);
        shadow_d = wr ? merged : shadow_q;
        valid_d  = DIRECT ? wr : (commit_i && dirty_q);
        out_d    = DIRECT ? (wr ? merged : out_q) : (valid_d ? shadow_q : out_q);
        dirty_d  = !DIRECT && !commit_i && (dirty_q || wr);
    end

    // state registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shadow_q <= '0;
            out_q    <= '0;
            dirty_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
            dirty_q  <= dirty_d;
            valid_q  <= valid_d;
        end
    end

    assign shadow_o = shadow_q;
    assign out_o    = out_q;
    assign dirty_o  = dirty_q;
    assign valid_o  = valid_q;
endmodule

// File: rtl/wb_register_bank_ppc2simulink.sv
// wb_register_bank_ppc2simulink: Wishbone-writable register bank with optional atomic commit
module wb_register_bank_ppc2simulink
    import wb_register_bank_ppc2simulink_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int COMMIT_MODE = 0
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    wb_register_bank_ppc2simulink_if.slave wb,
    output logic [NUM_REGS*32-1:0]       user_data_out,
    output logic [NUM_REGS-1:0]          user_data_valid
);
    logic [IDX_W-1:0]             idx;
    logic                         accept, in_range, is_ctrl, commit, any_dirty;
    logic                         ack_q, ack_d, err_q, err_d;
    logic [31:0]                  dat_q, dat_d, rd_val, ctrl_val;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NUM_REGS-1:0][31:0]    shadow_w;
    logic [NUM_REGS*32-1:0]       out_w;
    logic [NUM_REGS-1:0]          dirty_w, valid_w;
    logic                         unused_adr;

    assign unused_adr = ^{wb.wb_adr_i[31:7], wb.wb_adr_i[1:0]};
    assign idx        = wb.wb_adr_i[6:2];
    assign accept     = wb.wb_stb_i && wb.wb_cyc_i && !ack_q && !err_q && !wb_rst_i;
    assign in_range   = idx <= IDX_W'(NUM_REGS);
    assign is_ctrl    = idx == IDX_W'(NUM_REGS);
    assign commit     = (COMMIT_MODE == 1) && accept && wb.wb_we_i && is_ctrl && wb.wb_sel_i[CTRL_COMMIT_BIT] && wb.wb_dat_i[CTRL_COMMIT_BIT];
    assign any_dirty  = |dirty_w;

    // read mux, response and commit counter next state
    always_comb begin
        ctrl_val = '0;
        ctrl_val[CTRL_CNT_LSB +: CNT_W] = cnt_q;
        ctrl_val[CTRL_DIRTY_BIT] = any_dirty;
        ctrl_val[CTRL_MODE_BIT] = (COMMIT_MODE == 1);
        rd_val = is_ctrl ? ctrl_val : 32'h0;
        for (int i = 0; i < NUM_REGS; i++) rd_val = (idx == IDX_W'(i)) ? shadow_w[i] : rd_val;
        ack_d = accept && in_range;
        err_d = accept && !in_range;
        dat_d = rd_val;
        cnt_d = commit ? cnt_q + 1'b1 : cnt_q;
    end

    // response and counter registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
        wb_reg_slice #(.COMMIT_MODE(COMMIT_MODE)) u_slice (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .wr_i     (accept && wb.wb_we_i && (idx == IDX_W'(i))),
            .commit_i (commit),
            .dat_i    (wb.wb_dat_i),
            .sel_i    (wb.wb_sel_i),
            .shadow_o (shadow_w[i]),
            .out_o    (out_w[32*i +: 32]),
            .dirty_o  (dirty_w[i]),
            .valid_o  (valid_w[i])
        );
    end

    // reset masks the registered responses so a request accepted just before reset is never answered
    assign wb.wb_ack_o     = ack_q && !wb_rst_i;
    assign wb.wb_err_o     = err_q && !wb_rst_i;
    assign wb.wb_dat_o     = wb.wb_ack_o ? dat_q : 32'h0;
    assign user_data_out   = wb_rst_i ? '0 : out_w;
    assign user_data_valid = wb_rst_i ? '0 : valid_w;
endmodule

// File: tb/tb_wb_register_bank_ppc2simulink.sv
// tb_wb_register_bank_ppc2simulink: directed scoreboard bench for direct and commit modes
module tb_wb_register_bank_ppc2simulink;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        tgt, we, cyc, stb;
    logic [31:0] adr, dat;
    logic [3:0]  sel;

    wb_register_bank_ppc2simulink_if bus_d ();
    wb_register_bank_ppc2simulink_if bus_c ();
    logic [127:0] out_dw, out_cw;
    logic [3:0]   val_dw, val_cw;

    wb_register_bank_ppc2simulink #(.NUM_REGS(4), .COMMIT_MODE(0)) dut_d (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus_d.slave), .user_data_out(out_dw), .user_data_valid(val_dw));
    wb_register_bank_ppc2simulink #(.NUM_REGS(4), .COMMIT_MODE(1)) dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus_c.slave), .user_data_out(out_cw), .user_data_valid(val_cw));

    assign bus_d.wb_adr_i = adr;
    assign bus_d.wb_dat_i = dat;
    assign bus_d.wb_sel_i = sel;
    assign bus_d.wb_we_i  = we;
    assign bus_d.wb_cyc_i = cyc && !tgt;
    assign bus_d.wb_stb_i = stb && !tgt;
    assign bus_c.wb_adr_i = adr;
    assign bus_c.wb_dat_i = dat;
    assign bus_c.wb_sel_i = sel;
    assign bus_c.wb_we_i  = we;
    assign bus_c.wb_cyc_i = cyc && tgt;
    assign bus_c.wb_stb_i = stb && tgt;

    logic         ack, err;
    logic [31:0]  rdat;
    logic [127:0] outs;
    logic [3:0]   vals;
    assign ack  = tgt ? bus_c.wb_ack_o : bus_d.wb_ack_o;
    assign err  = tgt ? bus_c.wb_err_o : bus_d.wb_err_o;
    assign rdat = tgt ? bus_c.wb_dat_o : bus_d.wb_dat_o;
    assign outs = tgt ? out_cw : out_dw;
    assign vals = tgt ? val_cw : val_dw;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        bit          chk_dat;
    } resp_t;
    resp_t sb[$];

    int passes = 0;
    int fails = 0;
    int checks = 0;
    logic [3:0]   v1, v2;
    logic [127:0] o1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic txn(input bit t, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic e_ack, input logic e_err, input logic [31:0] e_dat, input bit cd, input string tag);
        resp_t r;
        @(negedge clk);
        tgt = t; we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        sb.push_back('{e_ack, e_err, e_dat, cd});
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0;
        r = sb.pop_front();
        chk({tag, ".ack"}, ack, r.ack);
        chk({tag, ".err"}, err, r.err);
        if (r.chk_dat) chk({tag, ".dat"}, rdat, r.dat);
        v1 = vals;
        o1 = outs;
        @(posedge clk);
        #1;
        chk({tag, ".one_cycle"}, {ack, err}, 2'b00);
        v2 = vals;
    endtask

    task automatic rd(input bit t, input logic [31:0] a, input logic [31:0] e, input string tag);
        txn(t, 1'b0, a, 32'h0, 4'h0, 1'b1, 1'b0, e, 1'b1, tag);
    endtask

    task automatic wr(input bit t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        txn(t, 1'b1, a, d, s, 1'b1, 1'b0, 32'h0, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tgt = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; cyc = 1'b0; stb = 1'b0;
        // reset state, with a write presented during reset that must be ignored
        repeat (2) @(posedge clk);
        @(negedge clk);
        we = 1'b1; adr = 32'h0; dat = 32'h55; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.resp_d", {bus_d.wb_ack_o, bus_d.wb_err_o, bus_d.wb_dat_o}, 34'h0);
        chk("rst.resp_c", {bus_c.wb_ack_o, bus_c.wb_err_o, bus_c.wb_dat_o}, 34'h0);
        chk("rst.out", {out_dw, out_cw}, 256'h0);
        chk("rst.valid", {val_dw, val_cw}, 8'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(0, 32'h0, 32'h0, "rst.ignored");

        // direct mode full write
        wr(0, 32'h8, 32'hDEADBEEF, 4'hF, "d.wr2");
        chk("d.wr2.valid", v1, 4'b0100);
        chk("d.wr2.out", o1, {32'h0, 32'hDEADBEEF, 64'h0});
        chk("d.wr2.valid_end", v2, 4'b0000);
        rd(0, 32'h8, 32'hDEADBEEF, "d.rd2");

        // byte lanes
        wr(0, 32'h4, 32'h11223344, 4'hF, "d.wr1");
        wr(0, 32'h4, 32'hAABBCCDD, 4'h5, "d.wr1.lanes");
        chk("d.lanes.out", o1[63:32], 32'h11BB33DD);
        rd(0, 32'h4, 32'h11BB33DD, "d.rd1");

        // zero byte enables
        wr(0, 32'h4, 32'hFFFFFFFF, 4'h0, "d.sel0");
        chk("d.sel0.valid", v1, 4'b0000);
        rd(0, 32'h4, 32'h11BB33DD, "d.sel0.rd");

        // CTRL in direct mode has no effect
        rd(0, 32'h10, 32'h0, "d.ctrl.rd");
        wr(0, 32'h10, 32'h1, 4'hF, "d.ctrl.wr");
        chk("d.ctrl.valid", v1, 4'b0000);

        // out of range
        txn(0, 1'b1, 32'h14, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0, 1'b1, "d.oor.wr");
        chk("d.oor.out", o1, {32'h0, 32'hDEADBEEF, 32'h11BB33DD, 32'h0});
        chk("d.oor.valid", v1, 4'b0000);
        txn(0, 1'b0, 32'h7C, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1, "d.oor.rd");
        rd(0, 32'h8, 32'hDEADBEEF, "d.oor.rd2");

        // commit mode: writes only touch shadows
        wr(1, 32'h0, 32'h1, 4'hF, "c.wr0");
        chk("c.wr0.valid", v1, 4'b0000);
        wr(1, 32'hC, 32'h3, 4'hF, "c.wr3");
        chk("c.wr3.out", o1, 128'h0);
        rd(1, 32'h10, 32'h00000003, "c.ctrl.dirty");
        rd(1, 32'h0, 32'h1, "c.shadow0");

        // first commit
        wr(1, 32'h10, 32'h1, 4'h1, "c.commit1");
        chk("c.commit1.valid", v1, 4'b1001);
        chk("c.commit1.out", o1, {32'h3, 64'h0, 32'h1});
        chk("c.commit1.valid_end", v2, 4'b0000);
        rd(1, 32'h10, 32'h00010001, "c.ctrl1");

        // empty commit
        wr(1, 32'h10, 32'h1, 4'h1, "c.commit2");
        chk("c.commit2.valid", v1, 4'b0000);
        chk("c.commit2.out", o1, {32'h3, 64'h0, 32'h1});
        rd(1, 32'h10, 32'h00020001, "c.ctrl2");

        // CTRL writes that do not commit
        wr(1, 32'h4, 32'hA5A5A5A5, 4'hF, "c.wr1");
        wr(1, 32'h10, 32'h0, 4'h1, "c.nocommit.bit0");
        wr(1, 32'h10, 32'h1, 4'h2, "c.nocommit.sel");
        chk("c.nocommit.valid", v1, 4'b0000);
        rd(1, 32'h10, 32'h00020003, "c.ctrl.pending");
        wr(1, 32'h10, 32'h1, 4'hF, "c.commit3");
        chk("c.commit3.valid", v1, 4'b0010);
        chk("c.commit3.out", o1, {32'h3, 32'h0, 32'hA5A5A5A5, 32'h1});

        // reset asserted the cycle after a write is accepted
        @(negedge clk);
        tgt = 1'b1; we = 1'b1; adr = 32'h4; dat = 32'hCAFEF00D; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; rst = 1'b1;
        #1;
        chk("rstmid.resp", {ack, err, rdat}, 34'h0);
        chk("rstmid.out", outs, 128'h0);
        chk("rstmid.valid", vals, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(1, 32'h4, 32'h0, "rstmid.shadow");
        rd(1, 32'h10, 32'h00000001, "rstmid.ctrl");
        chk("rstmid.out_after", outs, 128'h0);

        // counter wrap, preloaded near the top
        @(negedge clk);
        force dut_c.cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut_c.cnt_q;
        rd(1, 32'h10, 32'hFFFE0001, "wrap.pre");
        wr(1, 32'h10, 32'h1, 4'h1, "wrap.c1");
        rd(1, 32'h10, 32'hFFFF0001, "wrap.top");
        wr(1, 32'h10, 32'h1, 4'h1, "wrap.c2");
        rd(1, 32'h10, 32'h00000001, "wrap.zero");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
